// File: rtl/axi4lite_master_arbiter.sv
// Two-requester arbiter sharing one AXI4-Lite master port, one transaction in flight.
// Define AXI4L_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module axi4lite_master_arbiter #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,

    input  logic [1:0]                      REQ_VALID,
    output logic [1:0]                      REQ_READY,
    input  logic [1:0]                      REQ_WRITE,
    input  logic [2*C_M_AXI_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [2*C_M_AXI_DATA_WIDTH-1:0] REQ_WDATA,
    output logic [1:0]                      REQ_DONE,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   REQ_RDATA,
    output logic [1:0]                      REQ_RESP,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t          state;
    logic            owner;
    logic            winner;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            aw_finishing;
    logic            w_finishing;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

`ifdef AXI4L_ARB_FIXED_PRIO_EN
    assign winner = ~REQ_VALID[0];
`else
    // prio_ptr names the requester that wins when both are valid
    logic prio_ptr;

    assign winner = (&REQ_VALID) ? prio_ptr : ~REQ_VALID[0];

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            prio_ptr <= 1'b0;
        end else if (accept) begin
            prio_ptr <= ~winner;
        end
    end
`endif

    assign accept    = (state == IDLE) && (|REQ_VALID) && !M_AXI_ARESET;
    assign REQ_READY = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign sel_addr  = winner ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
    assign sel_wdata = winner ? REQ_WDATA[2*DW-1:DW] : REQ_WDATA[DW-1:0];

    // A write channel counts as finished if it already handshook or does so this edge
    assign aw_finishing = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_finishing  = !M_AXI_WVALID  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state         <= IDLE;
            owner         <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            REQ_DONE      <= 2'b00;
            REQ_RDATA     <= '0;
            REQ_RESP      <= 2'b00;
        end else begin
            REQ_DONE <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= winner;
                        if (REQ_WRITE[winner]) begin
                            M_AXI_AWADDR  <= sel_addr;
                            M_AXI_WDATA   <= sel_wdata;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_ADDR_DATA;
                        end else begin
                            M_AXI_ARADDR  <= sel_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (M_AXI_WVALID && M_AXI_WREADY) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (aw_finishing && w_finishing) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        REQ_RESP     <= M_AXI_BRESP;
                        REQ_RDATA    <= '0;
                        REQ_DONE     <= owner ? 2'b10 : 2'b01;
                        state        <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        REQ_RESP     <= M_AXI_RRESP;
                        REQ_RDATA    <= M_AXI_RDATA;
                        REQ_DONE     <= owner ? 2'b10 : 2'b01;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
